apuracao_resultado: RTL and testbench
=====================================

APURACAO_RESULTADO -- requirements
Module: apuracao_resultado

Interface
REQ-001 The block SHALL have parameter DWELL, default 4: clock cycles each candidate result is held on the display outputs (legal range 1..255).
REQ-002 Port clock, input, 1 bit: single rising-edge clock for all state.
REQ-003 Port reset_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 Port finish, input, 1 bit: end-of-election level from the voting core; its rising edge starts tallying.
REQ-005 Ports totalvotos_matheus, totalvotos_luis, totalvotos_vinicius, totalvotos_random, totalvotos_nulos, input, 8 bits each: running totals from the voting core.
REQ-006 Port winner, output, 3 bits: candidate code of the winner (0 matheus, 1 luis, 2 vinicius, 3 random, 7 none).
REQ-007 Port tie, output, 1 bit: high when two or more candidates share the maximum nonzero total.
REQ-008 Port done, output, 1 bit: winner and tie are valid.
REQ-009 Port disp_sel, output, 3 bits: code of the total currently shown (0..3 candidates, 4 nulos).
REQ-010 Ports disp_centena, disp_dezena, disp_unidade, output, 4 bits each: BCD digits of the shown total.
REQ-011 Port disp_valid, output, 1 bit: the display outputs are stable and meaningful.

Function
REQ-012 The FSM SHALL have the states IDLE, LATCH, COMPARE, CONVERT and SHOW.
REQ-013 A finish rising edge SHALL be detected as finish sampled 1 while the registered previous finish is 0; level-high finish without an edge (e.g. out of reset) SHALL NOT start tallying.
REQ-014 On edge detection, IDLE->LATCH; in LATCH, all five totals SHALL be copied into internal registers, and later input changes SHALL be ignored.
REQ-015 COMPARE SHALL last exactly 3 cycles, comparing luis, vinicius, random in order against a running max seeded with matheus.
REQ-016 In COMPARE, strictly greater SHALL replace max and index and clear tie; equal and nonzero SHALL set tie; smaller SHALL change nothing; nulos SHALL never participate.
REQ-017 If all four candidate totals are 0, winner SHALL be 7 and tie 0.
REQ-018 When tie=1, winner SHALL hold the lowest candidate code among those sharing the maximum.
REQ-019 done, winner and tie SHALL update together, 5 cycles after the edge-detect cycle (1 LATCH + 3 COMPARE + 1 register), and SHALL hold until IDLE.
REQ-020 After COMPARE, disp_sel SHALL start at 0; CONVERT SHALL run a sequential binary-to-BCD conversion of the selected total in exactly 8 cycles with disp_valid=0.
REQ-021 SHOW SHALL present the digits with disp_valid=1 for exactly DWELL cycles, then increment disp_sel and go to CONVERT; after disp_sel=4 it SHALL wrap to 0.
REQ-022 The display cycle SHALL repeat indefinitely while finish stays 1.
REQ-023 finish=0 in any non-IDLE state SHALL force IDLE on the next edge and clear done, tie, disp_valid, winner=7, disp_sel=0 and the digits to 0.
REQ-024 A new finish rising edge SHALL restart from LATCH with freshly latched totals.
REQ-025 Value 255 SHALL convert to 2,5,5; value 0 to 0,0,0; BCD digits SHALL never exceed 9.

Reset
REQ-026 reset_n=0 SHALL asynchronously force IDLE, finish history 0, winner=7, tie=0, done=0, disp_sel=0, disp_valid=0, all digits 0, and internal latches and counters 0.
REQ-027 Release SHALL be synchronised to clock (two-flop release); the first edge can be detected no earlier than the second cycle after release.

Structure
REQ-028 The package apuracao_pkg SHALL hold the state encoding, candidate codes 0..4, the code WINNER_NONE=7 and the constant BCD_CYCLES=8.
REQ-029 The conversion SHALL be a sub-module bin2bcd_seq (inputs start and an 8-bit value; outputs busy, done and three BCD digits), instantiated once.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Totals M=2, L=1, V=1, R=0, N=1, finish rise -> done at +5 cycles, winner=0, tie=0.
- Totals M=1, L=3, V=3, R=2 -> winner=1, tie=1.
- All candidates 0, N=5 -> winner=7, tie=0; the sel=4 display shows 0,0,5.
- M=255, DWELL=4 -> sel 0 shows 2,5,5 for 4 cycles with disp_valid=1 after 8 invalid cycles; sequence 0,1,2,3,4,0 verified.
- finish dropped mid-CONVERT -> all outputs cleared next cycle; the re-raised finish latches new totals.
- reset_n pulsed low mid-SHOW (asynchronously, between edges) -> outputs cleared immediately, no tally until a fresh finish edge.

Source files
------------

// File: rtl/apuracao_pkg.sv
// Shared types and constants for the election result tally: FSM encoding,
// candidate codes and the shift-and-add-3 step used by the BCD converter.
package apuracao_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LATCH   = 3'd1,
        COMPARE = 3'd2,
        CONVERT = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [2:0] CAND_MATHEUS  = 3'd0;
    localparam logic [2:0] CAND_LUIS     = 3'd1;
    localparam logic [2:0] CAND_VINICIUS = 3'd2;
    localparam logic [2:0] CAND_RANDOM   = 3'd3;
    localparam logic [2:0] CAND_NULOS    = 3'd4;
    localparam logic [2:0] WINNER_NONE   = 3'd7;

    localparam logic [3:0] BCD_CYCLES = 4'd8;
    localparam logic [1:0] CMP_LAST   = 2'd2;

    function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

    // One double-dabble iteration: correct each digit, then shift in the next binary bit.
    function automatic logic [11:0] bcd_shift_step(input logic [11:0] bcd, input logic bit_in);
        logic [11:0] adj;
        adj = {bcd_add3(bcd[11:8]), bcd_add3(bcd[7:4]), bcd_add3(bcd[3:0])};
        return (adj << 1) | {11'd0, bit_in};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to three-digit BCD converter: one bit per cycle,
// BCD_CYCLES iterations from the start cycle to the done pulse.
module bin2bcd_seq
    import apuracao_pkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_centena,
    output logic [3:0] bcd_dezena,
    output logic [3:0] bcd_unidade
);

    localparam logic [3:0] BCD_LAST = BCD_CYCLES - 4'd1;

    logic [7:0]  shift_r;
    logic [11:0] bcd_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic        done_r;

    // The start cycle already performs the first iteration so the run is exactly BCD_CYCLES long.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= 8'd0;
            bcd_r   <= 12'd0;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                bcd_r   <= bcd_shift_step(12'd0, value[7]);
                shift_r <= {value[6:0], 1'b0};
                cnt_r   <= 4'd1;
                busy_r  <= 1'b1;
            end else if (busy_r) begin
                bcd_r   <= bcd_shift_step(bcd_r, shift_r[7]);
                shift_r <= {shift_r[6:0], 1'b0};
                cnt_r   <= cnt_r + 4'd1;
                if (cnt_r == BCD_LAST) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    busy_r <= 1'b1;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign bcd_centena = bcd_r[11:8];
    assign bcd_dezena  = bcd_r[7:4];
    assign bcd_unidade = bcd_r[3:0];

endmodule

// File: rtl/apuracao_resultado.sv
// Election result tally: latches the totals on a finish rising edge, picks the
// winner (with tie flag) and cycles every total through a BCD display.
module apuracao_resultado
    import apuracao_pkg::*;
#(
    parameter int unsigned DWELL = 4
)
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       finish,
    input  logic [7:0] totalvotos_matheus,
    input  logic [7:0] totalvotos_luis,
    input  logic [7:0] totalvotos_vinicius,
    input  logic [7:0] totalvotos_random,
    input  logic [7:0] totalvotos_nulos,
    output logic [2:0] winner,
    output logic       tie,
    output logic       done,
    output logic [2:0] disp_sel,
    output logic [3:0] disp_centena,
    output logic [3:0] disp_dezena,
    output logic [3:0] disp_unidade,
    output logic       disp_valid
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    logic [1:0]      rst_pipe_r;
    logic            rst_early_n_s;
    logic            rst_int_n_s;
    state_t          state_r;
    state_t          state_nx_s;
    logic            finish_prev_r;
    logic [4:0][7:0] lat_r;
    logic [7:0]      max_r;
    logic [2:0]      idx_r;
    logic            tie_run_r;
    logic [1:0]      cmp_cnt_r;
    logic            publish_r;
    logic [7:0]      dwell_cnt_r;
    logic [2:0]      winner_r;
    logic            tie_r;
    logic            done_r;
    logic [2:0]      disp_sel_r;
    logic            disp_valid_r;
    logic [3:0]      cent_r;
    logic [3:0]      dez_r;
    logic [3:0]      uni_r;

    logic            edge_s;
    logic            abort_s;
    logic            conv_start_s;
    logic            conv_finish_s;
    logic [2:0]      sel_nx_s;
    logic [7:0]      conv_value_s;
    logic [7:0]      cand_s;
    logic            conv_busy_s;
    logic            conv_done_s;
    logic [3:0]      conv_cent_s;
    logic [3:0]      conv_dez_s;
    logic [3:0]      conv_uni_s;

    function automatic logic [7:0] pick_total(input logic [4:0][7:0] tot, input logic [2:0] sel);
        logic [7:0] val;
        case (sel)
            CAND_MATHEUS:  val = tot[0];
            CAND_LUIS:     val = tot[1];
            CAND_VINICIUS: val = tot[2];
            CAND_RANDOM:   val = tot[3];
            CAND_NULOS:    val = tot[4];
            default:       val = 8'd0;
        endcase
        return val;
    endfunction

    // Two-flop release; asserting reset_n still clears everything immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe_r <= 2'b00;
        end else begin
            rst_pipe_r <= {rst_pipe_r[0], 1'b1};
        end
    end

    assign rst_early_n_s = rst_pipe_r[0];
    assign rst_int_n_s   = rst_pipe_r[1];

    // Finish history leaves reset one cycle before the FSM, so a level-high finish is never an edge.
    always_ff @(posedge clock or negedge rst_early_n_s) begin
        if (!rst_early_n_s) begin
            finish_prev_r <= 1'b0;
        end else begin
            finish_prev_r <= finish;
        end
    end

    assign edge_s        = finish & ~finish_prev_r;
    assign abort_s       = (state_r != IDLE) & ~finish;
    assign conv_finish_s = conv_done_s & ~conv_busy_s;

    // State register.
    always_ff @(posedge clock or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; also decides when a conversion starts and for which total.
    always_comb begin
        state_nx_s   = state_r;
        conv_start_s = 1'b0;
        sel_nx_s     = disp_sel_r;
        if (abort_s) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (edge_s) state_nx_s = LATCH;
                    else        state_nx_s = IDLE;
                end
                LATCH: begin
                    state_nx_s = COMPARE;
                end
                COMPARE: begin
                    if (cmp_cnt_r == CMP_LAST) begin
                        state_nx_s   = CONVERT;
                        conv_start_s = 1'b1;
                        sel_nx_s     = CAND_MATHEUS;
                    end else begin
                        state_nx_s = COMPARE;
                    end
                end
                CONVERT: begin
                    if (conv_finish_s) state_nx_s = SHOW;
                    else               state_nx_s = CONVERT;
                end
                SHOW: begin
                    if (dwell_cnt_r == DWELL_LAST) begin
                        state_nx_s   = CONVERT;
                        conv_start_s = 1'b1;
                        sel_nx_s     = (disp_sel_r == CAND_NULOS) ? CAND_MATHEUS : (disp_sel_r + 3'd1);
                    end else begin
                        state_nx_s = SHOW;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // Candidate under test in each compare step: luis, vinicius, random.
    always_comb begin
        case (cmp_cnt_r)
            2'd0:    cand_s = lat_r[1];
            2'd1:    cand_s = lat_r[2];
            2'd2:    cand_s = lat_r[3];
            default: cand_s = 8'd0;
        endcase
    end

    assign conv_value_s = pick_total(lat_r, sel_nx_s);

    // Datapath: latching, running max, result publication and display registers.
    always_ff @(posedge clock or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            lat_r        <= '0;
            max_r        <= 8'd0;
            idx_r        <= CAND_MATHEUS;
            tie_run_r    <= 1'b0;
            cmp_cnt_r    <= 2'd0;
            publish_r    <= 1'b0;
            dwell_cnt_r  <= 8'd0;
            winner_r     <= WINNER_NONE;
            tie_r        <= 1'b0;
            done_r       <= 1'b0;
            disp_sel_r   <= CAND_MATHEUS;
            disp_valid_r <= 1'b0;
            cent_r       <= 4'd0;
            dez_r        <= 4'd0;
            uni_r        <= 4'd0;
        end else if (abort_s) begin
            cmp_cnt_r    <= 2'd0;
            publish_r    <= 1'b0;
            dwell_cnt_r  <= 8'd0;
            winner_r     <= WINNER_NONE;
            tie_r        <= 1'b0;
            done_r       <= 1'b0;
            disp_sel_r   <= CAND_MATHEUS;
            disp_valid_r <= 1'b0;
            cent_r       <= 4'd0;
            dez_r        <= 4'd0;
            uni_r        <= 4'd0;
        end else begin
            if (publish_r) begin
                done_r    <= 1'b1;
                tie_r     <= tie_run_r;
                winner_r  <= (max_r == 8'd0) ? WINNER_NONE : idx_r;
                publish_r <= 1'b0;
            end
            if (conv_start_s) begin
                disp_sel_r <= sel_nx_s;
            end
            case (state_r)
                LATCH: begin
                    lat_r     <= {totalvotos_nulos, totalvotos_random, totalvotos_vinicius,
                                  totalvotos_luis, totalvotos_matheus};
                    max_r     <= totalvotos_matheus;
                    idx_r     <= CAND_MATHEUS;
                    tie_run_r <= 1'b0;
                    cmp_cnt_r <= 2'd0;
                end
                COMPARE: begin
                    // Only a strictly greater total moves the index, so ties keep the lowest code.
                    if (cand_s > max_r) begin
                        max_r     <= cand_s;
                        idx_r     <= {1'b0, cmp_cnt_r} + 3'd1;
                        tie_run_r <= 1'b0;
                    end else if ((cand_s == max_r) && (cand_s != 8'd0)) begin
                        tie_run_r <= 1'b1;
                    end else begin
                        tie_run_r <= tie_run_r;
                    end
                    cmp_cnt_r <= cmp_cnt_r + 2'd1;
                    if (cmp_cnt_r == CMP_LAST) begin
                        publish_r <= 1'b1;
                    end
                end
                CONVERT: begin
                    if (conv_finish_s) begin
                        cent_r       <= conv_cent_s;
                        dez_r        <= conv_dez_s;
                        uni_r        <= conv_uni_s;
                        disp_valid_r <= 1'b1;
                        dwell_cnt_r  <= 8'd0;
                    end
                end
                SHOW: begin
                    if (dwell_cnt_r == DWELL_LAST) begin
                        disp_valid_r <= 1'b0;
                    end else begin
                        dwell_cnt_r <= dwell_cnt_r + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clock       (clock),
        .rst_n       (rst_int_n_s),
        .start       (conv_start_s),
        .value       (conv_value_s),
        .busy        (conv_busy_s),
        .done        (conv_done_s),
        .bcd_centena (conv_cent_s),
        .bcd_dezena  (conv_dez_s),
        .bcd_unidade (conv_uni_s)
    );

    assign winner       = winner_r;
    assign tie          = tie_r;
    assign done         = done_r;
    assign disp_sel     = disp_sel_r;
    assign disp_valid   = disp_valid_r;
    assign disp_centena = cent_r;
    assign disp_dezena  = dez_r;
    assign disp_unidade = uni_r;

endmodule

// File: tb/tb_apuracao_resultado.sv
// Directed bench for apuracao_resultado: winner/tie rules, result latency,
// BCD display sequencing, finish abort and asynchronous reset.
module tb_apuracao_resultado;

    logic       clock;
    logic       reset_n;
    logic       finish;
    logic [7:0] t_m, t_l, t_v, t_r, t_n;
    logic [2:0] winner;
    logic       tie;
    logic       done;
    logic [2:0] disp_sel;
    logic [3:0] disp_centena, disp_dezena, disp_unidade;
    logic       disp_valid;

    int n_vec;
    int n_err;

    logic [7:0] wt_m [4] = '{8'd1, 8'd3, 8'd4, 8'd0};
    logic [7:0] wt_l [4] = '{8'd3, 8'd3, 8'd2, 8'd0};
    logic [7:0] wt_v [4] = '{8'd3, 8'd5, 8'd1, 8'd0};
    logic [7:0] wt_r [4] = '{8'd2, 8'd1, 8'd4, 8'd9};
    logic [2:0] wt_w [4] = '{3'd1, 3'd2, 3'd0, 3'd3};
    logic       wt_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic [3:0] dc_c [5] = '{4'd2, 4'd0, 4'd0, 4'd1, 4'd0};
    logic [3:0] dc_d [5] = '{4'd5, 4'd1, 4'd9, 4'd0, 4'd0};
    logic [3:0] dc_u [5] = '{4'd5, 4'd0, 4'd9, 4'd0, 4'd7};

    apuracao_resultado #(.DWELL(4)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .finish              (finish),
        .totalvotos_matheus  (t_m),
        .totalvotos_luis     (t_l),
        .totalvotos_vinicius (t_v),
        .totalvotos_random   (t_r),
        .totalvotos_nulos    (t_n),
        .winner              (winner),
        .tie                 (tie),
        .done                (done),
        .disp_sel            (disp_sel),
        .disp_centena        (disp_centena),
        .disp_dezena         (disp_dezena),
        .disp_unidade        (disp_unidade),
        .disp_valid          (disp_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_totals(input logic [7:0] m, l, v, r, n);
        t_m = m; t_l = l; t_v = v; t_r = r; t_n = n;
    endtask

    // Drop finish long enough to return to IDLE, then raise it; the next edge is the detect edge.
    task automatic raise_finish();
        finish = 1'b0;
        tick();
        tick();
        finish = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        finish  = 1'b1;
        set_totals(8'd3, 8'd1, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        n_vec++;
        if ({done, tie, winner, disp_valid, disp_sel, disp_centena, disp_dezena, disp_unidade}
            !== {1'b0, 1'b0, 3'd7, 1'b0, 3'd0, 12'h000}) begin
            n_err++;
            $display("FAIL reset_state: got done=%0b tie=%0b winner=%0d valid=%0b sel=%0d digits=%0d%0d%0d expected 0 0 7 0 0 000",
                     done, tie, winner, disp_valid, disp_sel, disp_centena, disp_dezena, disp_unidade);
        end
        reset_n = 1'b1;
        repeat (12) tick();
        n_vec++;
        if ({done, disp_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL level_finish_no_start: got done=%0b valid=%0b expected 0 0", done, disp_valid);
        end
        finish = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        set_totals(8'd2, 8'd1, 8'd1, 8'd0, 8'd1);
        raise_finish();
        repeat (5) tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_early: got done=%0b expected 0 at +4", done);
        end
        tick();
        n_vec++;
        if ({done, winner, tie} !== {1'b1, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL basic_winner: got done=%0b winner=%0d tie=%0b expected 1 0 0", done, winner, tie);
        end
    endtask

    task automatic test_winner_table();
        for (int i = 0; i < 4; i++) begin
            set_totals(wt_m[i], wt_l[i], wt_v[i], wt_r[i], 8'd1);
            raise_finish();
            repeat (6) tick();
            n_vec++;
            if ({done, winner, tie} !== {1'b1, wt_w[i], wt_t[i]}) begin
                n_err++;
                $display("FAIL winner_case%0d: got done=%0b winner=%0d tie=%0b expected 1 %0d %0b",
                         i, done, winner, tie, wt_w[i], wt_t[i]);
            end
        end
    endtask

    task automatic test_all_zero();
        int k;
        set_totals(8'd0, 8'd0, 8'd0, 8'd0, 8'd5);
        raise_finish();
        repeat (6) tick();
        n_vec++;
        if ({done, winner, tie} !== {1'b1, 3'd7, 1'b0}) begin
            n_err++;
            $display("FAIL all_zero_winner: got done=%0b winner=%0d tie=%0b expected 1 7 0", done, winner, tie);
        end
        k = 0;
        while (!(disp_valid === 1'b1 && disp_sel === 3'd4) && k < 200) begin
            tick();
            k++;
        end
        n_vec++;
        if (k >= 200) begin
            n_err++;
            $display("FAIL nulos_show_timeout: got no sel=4 display in 200 cycles expected one");
        end else if ({disp_centena, disp_dezena, disp_unidade} !== 12'h005) begin
            n_err++;
            $display("FAIL nulos_digits: got %0d%0d%0d expected 005", disp_centena, disp_dezena, disp_unidade);
        end
    endtask

    task automatic test_display_cycle();
        logic [2:0] es;
        set_totals(8'd255, 8'd10, 8'd99, 8'd100, 8'd7);
        raise_finish();
        repeat (3) tick();
        set_totals(8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
        repeat (2) tick();
        for (int p = 0; p < 6; p++) begin
            es = 3'(p % 5);
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if ({disp_valid, disp_sel} !== {1'b0, es}) begin
                    n_err++;
                    $display("FAIL convert_p%0d_c%0d: got valid=%0b sel=%0d expected 0 %0d", p, i, disp_valid, disp_sel, es);
                end
                tick();
            end
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if ({disp_valid, disp_sel, disp_centena, disp_dezena, disp_unidade}
                    !== {1'b1, es, dc_c[es], dc_d[es], dc_u[es]}) begin
                    n_err++;
                    $display("FAIL show_p%0d_c%0d: got valid=%0b sel=%0d digits=%0d%0d%0d expected 1 %0d %0d%0d%0d",
                             p, j, disp_valid, disp_sel, disp_centena, disp_dezena, disp_unidade,
                             es, dc_c[es], dc_d[es], dc_u[es]);
                end
                tick();
            end
        end
        n_vec++;
        if ({done, winner, tie} !== {1'b1, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL display_winner: got done=%0b winner=%0d tie=%0b expected 1 0 0", done, winner, tie);
        end
    endtask

    task automatic test_abort();
        set_totals(8'd5, 8'd9, 8'd1, 8'd1, 8'd2);
        raise_finish();
        repeat (19) tick();
        set_totals(8'd8, 8'd0, 8'd0, 8'd1, 8'd0);
        finish = 1'b0;
        tick();
        n_vec++;
        if ({done, tie, winner, disp_valid, disp_sel, disp_centena, disp_dezena, disp_unidade}
            !== {1'b0, 1'b0, 3'd7, 1'b0, 3'd0, 12'h000}) begin
            n_err++;
            $display("FAIL abort_clear: got done=%0b tie=%0b winner=%0d valid=%0b sel=%0d digits=%0d%0d%0d expected 0 0 7 0 0 000",
                     done, tie, winner, disp_valid, disp_sel, disp_centena, disp_dezena, disp_unidade);
        end
        finish = 1'b1;
        repeat (6) tick();
        n_vec++;
        if ({done, winner, tie} !== {1'b1, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL relatch_winner: got done=%0b winner=%0d tie=%0b expected 1 0 0", done, winner, tie);
        end
        repeat (7) tick();
        n_vec++;
        if ({disp_valid, disp_centena, disp_dezena, disp_unidade} !== {1'b1, 12'h008}) begin
            n_err++;
            $display("FAIL relatch_digits: got valid=%0b digits=%0d%0d%0d expected 1 008",
                     disp_valid, disp_centena, disp_dezena, disp_unidade);
        end
    endtask

    task automatic test_async_reset();
        int k;
        set_totals(8'd12, 8'd3, 8'd0, 8'd0, 8'd0);
        raise_finish();
        k = 0;
        while (disp_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        n_vec++;
        if (k >= 40) begin
            n_err++;
            $display("FAIL show_timeout: got no disp_valid in 40 cycles expected one");
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({done, tie, winner, disp_valid, disp_sel, disp_centena, disp_dezena, disp_unidade}
            !== {1'b0, 1'b0, 3'd7, 1'b0, 3'd0, 12'h000}) begin
            n_err++;
            $display("FAIL async_reset_clear: got done=%0b tie=%0b winner=%0d valid=%0b sel=%0d digits=%0d%0d%0d expected 0 0 7 0 0 000",
                     done, tie, winner, disp_valid, disp_sel, disp_centena, disp_dezena, disp_unidade);
        end
        #2;
        reset_n = 1'b1;
        repeat (12) tick();
        n_vec++;
        if ({done, disp_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL no_tally_after_reset: got done=%0b valid=%0b expected 0 0", done, disp_valid);
        end
        raise_finish();
        repeat (6) tick();
        n_vec++;
        if ({done, winner, tie} !== {1'b1, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL tally_after_reset: got done=%0b winner=%0d tie=%0b expected 1 0 0", done, winner, tie);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        finish  = 1'b0;
        set_totals(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_latency();
        test_winner_table();
        test_all_zero();
        test_display_cycle();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
